hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It reads the outputs of the ID/EX stage register (load destination, MemRead, Branch), the ID-stage source registers and the MEM-stage branch outcome. From these it drives the write-enable, bubble and flush controls for PC, IF/ID, ID/EX and EX/MEM. It also keeps a small action state register, saturating stall/flush counters and a memory-wait watchdog for debug.

## Interface
Parameters:
- `CNT_W`, default 32: width of the performance counters.
- `WD_LIMIT`, default 255: number of consecutive `mem_wait` cycles that trips the watchdog.

Ports:
- `clk` in 1: clock. This block has one clock.
- `rst` in 1: reset. Synchronous, active-high.
- `id_rs` in 5: rs field of the instruction in ID.
- `id_rt` in 5: rt field of the instruction in ID.
- `id_uses_rs` in 1: the ID instruction reads rs.
- `id_uses_rt` in 1: the ID instruction reads rt.
- `ex_memread` in 1: MemRead output of the ID/EX register.
- `ex_rt` in 5: Rt output of the ID/EX register (load destination).
- `mem_branch_taken` in 1: Branch AND zero, evaluated in the MEM stage.
- `mem_wait` in 1: data memory not ready. The MEM stage must hold.
- `pc_write` out 1: PC update enable.
- `ifid_write` out 1: IF/ID load enable.
- `ifid_flush` out 1: clear IF/ID to NOP.
- `idex_write` out 1: ID/EX load enable.
- `idex_bubble` out 1: load ID/EX with all control fields 0.
- `exmem_write` out 1: EX/MEM load enable.
- `exmem_flush` out 1: clear EX/MEM control fields.
- `pc_sel_branch` out 1: the PC mux selects the branch target.
- `state` out 2: action applied in the previous cycle.
- `stall_cnt` out CNT_W: total load-use stall cycles.
- `flush_cnt` out CNT_W: total branch flushes.
- `wait_cnt` out CNT_W: total mem_wait cycles.
- `wd_timeout` out 1: sticky watchdog flag.

## Operation
- Control outputs are combinational from the current inputs, so they act in the same cycle. `state`, the counters and `wd_timeout` are registered.
- Load-use hazard, called `lu`: `ex_memread` is 1, `ex_rt` is not 0, and at least one of the following holds:
  - `id_uses_rs` is 1 and `id_rs` equals `ex_rt`;
  - `id_uses_rt` is 1 and `id_rt` equals `ex_rt`.
- Priority, from highest to lowest:
  1. `mem_wait` (action WAIT):
     - Drive `pc_write`, `ifid_write`, `idex_write` and `exmem_write` to 0.
     - Drive all flush, bubble and `pc_sel_branch` outputs to 0.
     - A pending `mem_branch_taken` or `lu` is ignored and re-evaluated on the next cycle.
  2. `mem_branch_taken` (action FLUSH):
     - Drive `pc_sel_branch`, `pc_write`, `ifid_flush`, `idex_bubble` and `exmem_flush` to 1.
     - Enables stay 1.
     - `lu` is ignored, because the instruction in ID is on the wrong path.
  3. `lu` (action STALL):
     - Drive `pc_write` and `ifid_write` to 0.
     - Drive `idex_bubble` to 1.
     - `idex_write` and `exmem_write` stay 1.
  4. Otherwise (action RUN):
     - All enables are 1.
     - All flush, bubble and select outputs are 0.
- `state` encoding: RUN is 0, STALL is 1, FLUSH is 2, WAIT is 3. On every clock edge `state` takes the action of the current cycle.
- Counters:
  - `stall_cnt` increments on each STALL cycle.
  - `flush_cnt` increments on each FLUSH cycle.
  - `wait_cnt` increments on each WAIT cycle.
  - All counters saturate at all-ones and never wrap.
- Watchdog:
  - An internal run counter, 8+ bits wide, counts consecutive WAIT cycles.
  - It clears on any non-WAIT cycle.
  - When the run counter reaches `WD_LIMIT`, `wd_timeout` is set to 1. The run counter saturates there.
  - `wd_timeout` clears only on `rst`.

## Timing
- Reset values: `state`, all counters and `wd_timeout` are 0. While `rst` is 1, control outputs follow the RUN values (all enables 1, flush/bubble/select 0), and `mem_wait`, `lu` and `mem_branch_taken` are ignored.
- Zero-cycle latency from hazard inputs to control outputs.
- One cycle of latency to `state` and the counters.
- A load-use stall lasts exactly one cycle in the normal case: the bubble clears `ex_memread` on the next edge. Back-to-back STALL cycles are legal if the inputs demand them.
- If `mem_wait` lasts N cycles and then `mem_branch_taken` is seen, `state` shows N WAIT cycles, then one FLUSH.
- `mem_wait` and `lu` together: WAIT only. `stall_cnt` does not increment, and `lu` is evaluated again after the wait ends.
- Reset asserted mid-WAIT: counters and `wd_timeout` clear on the next edge. Outputs are RUN while `rst` is held.

## Test plan
- Load-use: `ex_memread`=1, `ex_rt`=8, `id_rs`=8, `id_uses_rs`=1 → same cycle `pc_write`=0, `ifid_write`=0, `idex_bubble`=1. Next cycle `state`=1 and `stall_cnt`=1. With `ex_rt`=0 instead, no stall.
- Branch flush with a simultaneous `lu` → `pc_sel_branch`=1, `ifid_flush`=1, `idex_bubble`=1, `exmem_flush`=1, `pc_write`=1. `flush_cnt`=1 and `stall_cnt`=0.
- Memory wait: `mem_wait`=1 for 3 cycles with `mem_branch_taken`=1 → all enables 0 and no flush for 3 cycles, then one FLUSH. `wait_cnt`=3 and `flush_cnt`=1.
- Watchdog with `WD_LIMIT`=4:
  - `mem_wait` for 3 cycles, one free cycle, then 3 more cycles → `wd_timeout` stays 0.
  - A further 4 consecutive cycles → `wd_timeout`=1, and it remains 1 after `mem_wait` drops.
- Saturation with `CNT_W`=3: 9 STALL cycles → `stall_cnt` reaches 7 and holds 7.
- `rst` pulsed during a WAIT run with nonzero counters → all counters, `state` and `wd_timeout` are 0 after the edge. Outputs are RUN values while `rst`=1.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard controller port bundle: ID/EX/MEM hazard inputs in, pipeline enables,
// flush controls and debug counters out.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [4:0]       ex_rt;
  logic             mem_branch_taken;
  logic             mem_wait;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_bubble;
  logic             exmem_write;
  logic             exmem_flush;
  logic             pc_sel_branch;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] wait_cnt;
  logic             wd_timeout;

  // Pipeline side: supplies hazard inputs, consumes controls.
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_rt,
           mem_branch_taken, mem_wait,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           exmem_write, exmem_flush, pc_sel_branch, state,
           stall_cnt, flush_cnt, wait_cnt, wd_timeout
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_rt,
           mem_branch_taken, mem_wait,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           exmem_write, exmem_flush, pc_sel_branch, state,
           stall_cnt, flush_cnt, wait_cnt, wd_timeout
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core: combinational stall,
// flush and wait controls plus registered action state, counters and watchdog.
module hazard_ctrl #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned WD_LIMIT = 255
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam int unsigned WD_BITS = $clog2(WD_LIMIT + 1);
  localparam int unsigned WD_W    = (WD_BITS > 8) ? WD_BITS : 8;
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(WD_LIMIT);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  logic             lu;
  logic [1:0]       act;
  logic             pc_write, ifid_write, ifid_flush, idex_write;
  logic             idex_bubble, exmem_write, exmem_flush, pc_sel_branch;
  logic [1:0]       state_q;
  logic [CNT_W-1:0] stall_q, flush_q, wait_q;
  logic [WD_W-1:0]  wd_run_q, wd_run_nxt;
  logic             wd_timeout_q;

  // Action selection: WAIT > FLUSH > STALL > RUN; reset forces RUN.
  always_comb begin
    lu  = 1'b0;
    act = ST_RUN;
    lu  = hz.ex_memread && (hz.ex_rt != 5'd0) &&
          ((hz.id_uses_rs && (hz.id_rs == hz.ex_rt)) ||
           (hz.id_uses_rt && (hz.id_rt == hz.ex_rt)));
    if (!rst) begin
      if (hz.mem_wait)              act = ST_WAIT;
      else if (hz.mem_branch_taken) act = ST_FLUSH;
      else if (lu)                  act = ST_STALL;
    end
  end

  // Control outputs decoded from the action of this cycle.
  always_comb begin
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_write    = 1'b1;
    idex_bubble   = 1'b0;
    exmem_write   = 1'b1;
    exmem_flush   = 1'b0;
    pc_sel_branch = 1'b0;
    case (act)
      ST_STALL: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      ST_FLUSH: begin
        pc_sel_branch = 1'b1;
        ifid_flush    = 1'b1;
        idex_bubble   = 1'b1;
        exmem_flush   = 1'b1;
      end
      ST_WAIT: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
      end
      default: ;
    endcase
  end

  // Consecutive-WAIT run length, saturating at the watchdog limit.
  always_comb begin
    wd_run_nxt = '0;
    if (act == ST_WAIT) begin
      wd_run_nxt = (wd_run_q >= WD_LIM) ? wd_run_q : wd_run_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      stall_q      <= '0;
      flush_q      <= '0;
      wait_q       <= '0;
      wd_run_q     <= '0;
      wd_timeout_q <= 1'b0;
    end else begin
      state_q  <= act;
      wd_run_q <= wd_run_nxt;
      if (act == ST_STALL && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
      if (act == ST_FLUSH && flush_q != '1) flush_q <= flush_q + CNT_W'(1);
      if (act == ST_WAIT  && wait_q  != '1) wait_q  <= wait_q  + CNT_W'(1);
      if (act == ST_WAIT && wd_run_nxt >= WD_LIM) wd_timeout_q <= 1'b1;
    end
  end

  assign hz.pc_write      = pc_write;
  assign hz.ifid_write    = ifid_write;
  assign hz.ifid_flush    = ifid_flush;
  assign hz.idex_write    = idex_write;
  assign hz.idex_bubble   = idex_bubble;
  assign hz.exmem_write   = exmem_write;
  assign hz.exmem_flush   = exmem_flush;
  assign hz.pc_sel_branch = pc_sel_branch;
  assign hz.state         = state_q;
  assign hz.stall_cnt     = stall_q;
  assign hz.flush_cnt     = flush_q;
  assign hz.wait_cnt      = wait_q;
  assign hz.wd_timeout    = wd_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (CNT_W=3, WD_LIMIT=4) with a reference model
// feeding a queue of expected registered outputs.
module tb_hazard_ctrl;

  localparam int unsigned CW  = 3;
  localparam int          LIM = 4;
  localparam int          SAT = 7;

  typedef struct {
    logic [1:0] st;
    int         sc;
    int         fc;
    int         wc;
    logic       wd;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  exp_t q[$];

  // reference model state
  logic [1:0] m_state;
  int         m_stall, m_flush, m_wait, m_run;
  logic       m_wd;

  hazard_ctrl_if #(.CNT_W(CW)) hz ();

  hazard_ctrl #(.CNT_W(CW), .WD_LIMIT(LIM)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, exmem_flush, pc_sel_branch}
  function automatic logic [7:0] ctrl_of(input logic [1:0] a);
    case (a)
      2'd1:    return 8'b0001_1100;
      2'd2:    return 8'b1111_1111;
      2'd3:    return 8'b0000_0000;
      default: return 8'b1101_0100;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check controls mid-cycle, then check registered outputs.
  task automatic step(input logic r, input logic mw, input logic bt, input logic mr,
                      input logic [4:0] xrt, input logic [4:0] rs, input logic urs,
                      input logic [4:0] rt, input logic urt);
    logic       m_lu;
    logic [1:0] a;
    exp_t       e;
    exp_t       got;
    rst                 = r;
    hz.mem_wait         = mw;
    hz.mem_branch_taken = bt;
    hz.ex_memread       = mr;
    hz.ex_rt            = xrt;
    hz.id_rs            = rs;
    hz.id_uses_rs       = urs;
    hz.id_rt            = rt;
    hz.id_uses_rt       = urt;
    #2;
    m_lu = mr && (xrt != 5'd0) && ((urs && rs == xrt) || (urt && rt == xrt));
    if (r)         a = 2'd0;
    else if (mw)   a = 2'd3;
    else if (bt)   a = 2'd2;
    else if (m_lu) a = 2'd1;
    else           a = 2'd0;
    chk("ctrl", 32'({hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_write,
                     hz.idex_bubble, hz.exmem_write, hz.exmem_flush, hz.pc_sel_branch}),
        32'(ctrl_of(a)));
    if (r) begin
      m_state = 2'd0; m_stall = 0; m_flush = 0; m_wait = 0; m_run = 0; m_wd = 1'b0;
    end else begin
      m_state = a;
      if (a == 2'd1 && m_stall < SAT) m_stall++;
      if (a == 2'd2 && m_flush < SAT) m_flush++;
      if (a == 2'd3 && m_wait  < SAT) m_wait++;
      if (a == 2'd3) begin
        if (m_run < LIM) m_run++;
        if (m_run == LIM) m_wd = 1'b1;
      end else begin
        m_run = 0;
      end
    end
    e.st = m_state; e.sc = m_stall; e.fc = m_flush; e.wc = m_wait; e.wd = m_wd;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      got = q.pop_front();
      chk("state",      32'(hz.state),      32'(got.st));
      chk("stall_cnt",  32'(hz.stall_cnt),  32'(got.sc));
      chk("flush_cnt",  32'(hz.flush_cnt),  32'(got.fc));
      chk("wait_cnt",   32'(hz.wait_cnt),   32'(got.wc));
      chk("wd_timeout", 32'(hz.wd_timeout), 32'(got.wd));
    end
  endtask

  task automatic idle();           step(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic reset_cyc();      step(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic wait_cyc(input logic bt); step(0, 1, bt, 1, 8, 8, 1, 0, 0); endtask
  task automatic stall_cyc();      step(0, 0, 0, 1, 8, 8, 1, 0, 0); endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_state = 2'd0; m_stall = 0; m_flush = 0; m_wait = 0; m_run = 0; m_wd = 1'b0;

    // Reset with every hazard asserted: RUN controls, registers cleared.
    step(1, 1, 1, 1, 8, 8, 1, 8, 1);
    step(1, 1, 1, 1, 8, 8, 1, 8, 1);
    chk("rst_state", 32'(hz.state), 32'd0);
    chk("rst_wd",    32'(hz.wd_timeout), 32'd0);

    // Load-use on rs: same-cycle stall, then state=STALL, stall_cnt=1.
    stall_cyc();
    chk("lu_state", 32'(hz.state), 32'd1);
    chk("lu_stall_cnt", 32'(hz.stall_cnt), 32'd1);
    idle();
    step(0, 0, 0, 1, 0, 0, 1, 0, 1);     // ex_rt=0: no stall
    chk("lu_rt0_state", 32'(hz.state), 32'd0);
    step(0, 0, 0, 1, 9, 3, 1, 9, 1);     // match via rt
    step(0, 0, 0, 1, 9, 9, 0, 4, 1);     // rs matches but unused
    step(0, 0, 0, 0, 9, 9, 1, 9, 1);     // not a load
    stall_cyc();                          // back-to-back stalls
    stall_cyc();

    // Branch flush overriding a simultaneous load-use.
    reset_cyc();
    step(0, 0, 1, 1, 8, 8, 1, 0, 0);
    chk("br_flush_cnt", 32'(hz.flush_cnt), 32'd1);
    chk("br_stall_cnt", 32'(hz.stall_cnt), 32'd0);
    chk("br_state",     32'(hz.state),     32'd2);

    // Memory wait masks a pending branch for 3 cycles, then one FLUSH.
    reset_cyc();
    for (int i = 0; i < 3; i++) wait_cyc(1);
    chk("mw_state", 32'(hz.state), 32'd3);
    chk("mw_stall_cnt", 32'(hz.stall_cnt), 32'd0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle();
    chk("mw_wait_cnt",  32'(hz.wait_cnt),  32'd3);
    chk("mw_flush_cnt", 32'(hz.flush_cnt), 32'd1);

    // Wait then lu: stall applies only after the wait ends.
    reset_cyc();
    wait_cyc(0);
    stall_cyc();
    chk("mwlu_stall_cnt", 32'(hz.stall_cnt), 32'd1);

    // Watchdog: broken runs do not trip, 4 consecutive do, and it is sticky.
    reset_cyc();
    for (int i = 0; i < 3; i++) wait_cyc(0);
    idle();
    for (int i = 0; i < 3; i++) wait_cyc(0);
    idle();
    chk("wd_short_runs", 32'(hz.wd_timeout), 32'd0);
    for (int i = 0; i < 3; i++) wait_cyc(0);
    chk("wd_three", 32'(hz.wd_timeout), 32'd0);
    wait_cyc(0);
    chk("wd_four", 32'(hz.wd_timeout), 32'd1);
    wait_cyc(0);
    idle();
    idle();
    chk("wd_sticky", 32'(hz.wd_timeout), 32'd1);

    // Counter saturation at 7.
    reset_cyc();
    for (int i = 0; i < 9; i++) stall_cyc();
    chk("sat_stall_cnt", 32'(hz.stall_cnt), 32'd7);
    stall_cyc();
    chk("sat_hold", 32'(hz.stall_cnt), 32'd7);

    // Reset in the middle of a WAIT run with nonzero counters.
    reset_cyc();
    stall_cyc();
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) wait_cyc(1);
    step(1, 1, 1, 1, 8, 8, 1, 8, 1);
    chk("midrst_state", 32'(hz.state),      32'd0);
    chk("midrst_stall", 32'(hz.stall_cnt),  32'd0);
    chk("midrst_flush", 32'(hz.flush_cnt),  32'd0);
    chk("midrst_wait",  32'(hz.wait_cnt),   32'd0);
    chk("midrst_wd",    32'(hz.wd_timeout), 32'd0);
    step(1, 1, 1, 1, 8, 8, 1, 8, 1);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
